// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control FSM states, register-0 constant and
// the register-address width used by the pipeline registers and register file.
package pipeline_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 4;
    localparam int unsigned ZERO_REG       = 0;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } ctrlState_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush control for the PC and the four inter-stage pipeline registers.
// Outputs are a combinational decode of the FSM state and the current hazards.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = pipeline_pkg::REG_ADDR_WIDTH,
    parameter int unsigned MEM_LATENCY    = 2,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      exMemMemAccess,
    input  logic                      exMemBranchTaken,
    input  logic                      idExMemRead,
    input  logic [REG_ADDR_WIDTH-1:0] idExDest,
    input  logic [REG_ADDR_WIDTH-1:0] ifIdSrc1,
    input  logic [REG_ADDR_WIDTH-1:0] ifIdSrc2,
    input  logic                      ifIdUse1,
    input  logic                      ifIdUse2,
    output logic                      pcWrEn,
    output logic                      ifIdWrEn,
    output logic                      idExWrEn,
    output logic                      exMemWrEn,
    output logic                      memWbWrEn,
    output logic                      ifIdFlush,
    output logic                      idExFlush,
    output logic                      exMemFlush,
    output logic [CNT_WIDTH-1:0]      stallCount
);

    localparam bit          MEM_EN = (MEM_LATENCY > 0);
    // A zero latency still needs a 1-bit counter to keep the declaration legal.
    localparam int unsigned WAIT_W = MEM_EN ? $clog2(MEM_LATENCY + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = MEM_EN ? WAIT_W'(MEM_LATENCY - 1) : '0;

    ctrlState_t        state, nextState;
    logic [WAIT_W-1:0] waitCnt, nextWait;
    logic              loadUse;

    assign loadUse = idExMemRead
                  && (idExDest != REG_ADDR_WIDTH'(ZERO_REG))
                  && ((ifIdUse1 && (ifIdSrc1 == idExDest))
                   || (ifIdUse2 && (ifIdSrc2 == idExDest)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWait;
        end
    end

    always_comb begin
        nextState  = state;
        nextWait   = waitCnt;
        pcWrEn     = 1'b1;
        ifIdWrEn   = 1'b1;
        idExWrEn   = 1'b1;
        exMemWrEn  = 1'b1;
        memWbWrEn  = 1'b1;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        exMemFlush = 1'b0;

        case (state)
            RUN: begin
                if (exMemMemAccess && MEM_EN) begin
                    {pcWrEn, ifIdWrEn, idExWrEn, exMemWrEn, memWbWrEn} = '0;
                    nextState = MEM_WAIT;
                    nextWait  = WAIT_LOAD;
                end else if (exMemBranchTaken) begin
                    {ifIdFlush, idExFlush, exMemFlush} = '1;
                end else if (loadUse) begin
                    pcWrEn    = 1'b0;
                    ifIdWrEn  = 1'b0;
                    idExFlush = 1'b1;
                end
            end
            MEM_WAIT: begin
                // The release cycle returns to RUN without re-examining inputs,
                // so the access still sitting in EX/MEM cannot re-trigger.
                if (waitCnt != '0) begin
                    {pcWrEn, ifIdWrEn, idExWrEn, exMemWrEn, memWbWrEn} = '0;
                    nextWait = waitCnt - WAIT_W'(1);
                end else begin
                    nextState = RUN;
                end
            end
            default: nextState = RUN;
        endcase

        if (reset) begin
            {pcWrEn, ifIdWrEn, idExWrEn, exMemWrEn, memWbWrEn} = '0;
            {ifIdFlush, idExFlush, exMemFlush}                 = '0;
        end
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) stallCounter (
        .clk  (clk),
        .reset(reset),
        .inc  (!reset && !pcWrEn),
        .count(stallCount)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: two instances (default latency, and
// latency 3 with a 2-bit counter) driven in lockstep against a cycle model.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset, exMemMemAccess, exMemBranchTaken, idExMemRead;
    logic [3:0] idExDest, ifIdSrc1, ifIdSrc2;
    logic       ifIdUse1, ifIdUse2;

    logic [4:0]  wrA, wrB;
    logic [2:0]  flA, flB;
    logic [31:0] cntA;
    logic [1:0]  cntB;

    int total = 0;
    int bad   = 0;

    int       lat[2]    = '{2, 3};
    longint   maxCnt[2] = '{64'hFFFF_FFFF, 3};
    longint   mCnt[2]   = '{0, 0};
    bit       inWait[2] = '{0, 0};
    int       left[2]   = '{0, 0};
    logic [4:0]  expWr[2];
    logic [2:0]  expFl[2];
    longint      expCnt[2];

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .REG_ADDR_WIDTH(4),
        .MEM_LATENCY   (2),
        .CNT_WIDTH     (32)
    ) dut (
        .clk(clk), .reset(reset),
        .exMemMemAccess(exMemMemAccess), .exMemBranchTaken(exMemBranchTaken),
        .idExMemRead(idExMemRead), .idExDest(idExDest),
        .ifIdSrc1(ifIdSrc1), .ifIdSrc2(ifIdSrc2),
        .ifIdUse1(ifIdUse1), .ifIdUse2(ifIdUse2),
        .pcWrEn(wrA[4]), .ifIdWrEn(wrA[3]), .idExWrEn(wrA[2]),
        .exMemWrEn(wrA[1]), .memWbWrEn(wrA[0]),
        .ifIdFlush(flA[2]), .idExFlush(flA[1]), .exMemFlush(flA[0]),
        .stallCount(cntA)
    );

    pipeline_ctrl #(
        .REG_ADDR_WIDTH(4),
        .MEM_LATENCY   (3),
        .CNT_WIDTH     (2)
    ) dutSlow (
        .clk(clk), .reset(reset),
        .exMemMemAccess(exMemMemAccess), .exMemBranchTaken(exMemBranchTaken),
        .idExMemRead(idExMemRead), .idExDest(idExDest),
        .ifIdSrc1(ifIdSrc1), .ifIdSrc2(ifIdSrc2),
        .ifIdUse1(ifIdUse1), .ifIdUse2(ifIdUse2),
        .pcWrEn(wrB[4]), .ifIdWrEn(wrB[3]), .idExWrEn(wrB[2]),
        .exMemWrEn(wrB[1]), .memWbWrEn(wrB[0]),
        .ifIdFlush(flB[2]), .idExFlush(flB[1]), .exMemFlush(flB[0]),
        .stallCount(cntB)
    );

    function automatic logic [39:0] observed(input int i);
        return (i == 0) ? {wrA, flA, cntA} : {wrB, flB, 30'd0, cntB};
    endfunction

    function automatic logic [39:0] expected(input int i);
        return {expWr[i], expFl[i], 32'(expCnt[i])};
    endfunction

    // Apply one cycle of inputs, then derive what each instance should show now
    // and advance the model to the state it will hold after the coming edge.
    task automatic drive(input bit r, acc, br, mr, input logic [3:0] dest, s1, s2,
                         input bit u1, u2);
        logic [4:0] w;
        logic [2:0] f;
        bit         lu;
        @(negedge clk);
        reset = r; exMemMemAccess = acc; exMemBranchTaken = br; idExMemRead = mr;
        idExDest = dest; ifIdSrc1 = s1; ifIdSrc2 = s2; ifIdUse1 = u1; ifIdUse2 = u2;
        #1;
        lu = mr && (dest != 0) && ((u1 && s1 == dest) || (u2 && s2 == dest));
        for (int i = 0; i < 2; i++) begin
            expCnt[i] = mCnt[i];
            if (r) begin
                w = '0; f = '0; inWait[i] = 0; left[i] = 0;
            end else if (inWait[i]) begin
                f = '0;
                if (left[i] > 0) begin w = '0; left[i]--; end
                else begin w = '1; inWait[i] = 0; end
            end else if (acc && lat[i] > 0) begin
                w = '0; f = '0; inWait[i] = 1; left[i] = lat[i] - 1;
            end else if (br) begin
                w = '1; f = '1;
            end else if (lu) begin
                w = 5'b00111; f = 3'b010;
            end else begin
                w = '1; f = '0;
            end
            expWr[i] = w;
            expFl[i] = f;
            if (r) mCnt[i] = 0;
            else if (!w[4] && mCnt[i] < maxCnt[i]) mCnt[i]++;
        end
    endtask

    task automatic quiet();
        drive(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (observed(i)[39:32] !== expected(i)[39:32]) begin
                bad++;
                $display("FAIL reset_first[%0d]: got wr/fl=%b want %b", i,
                         observed(i)[39:32], expected(i)[39:32]);
            end
        end
        drive(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        quiet();
        drive(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        quiet();
        // dutSlow now sits in MEM_WAIT with one frozen cycle still owed
        for (int c = 0; c < 4; c++) begin
            if (c < 2) drive(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
            else quiet();
            for (int i = 0; i < 2; i++) begin
                total++;
                if (observed(i) !== expected(i)) begin
                    bad++;
                    $display("FAIL reset_midwait[%0d] c%0d: got %h want %h", i, c,
                             observed(i), expected(i));
                end
            end
        end
    endtask

    task automatic test_mem_stall();
        drive(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            if (c == 0) drive(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
            else quiet();
            for (int i = 0; i < 2; i++) begin
                total++;
                if (observed(i) !== expected(i)) begin
                    bad++;
                    $display("FAIL mem_stall[%0d] c%0d: got %h want %h", i, c,
                             observed(i), expected(i));
                end
            end
        end
        total++;
        if (cntA !== 32'd2) begin
            bad++;
            $display("FAIL mem_stall_count: got %0d want 2", cntA);
        end
    endtask

    task automatic test_load_use();
        drive(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: drive(0, 0, 0, 1, 4'd5, 4'd1, 4'd5, 0, 1);
                2: drive(0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 1, 1);
                3: drive(0, 0, 0, 1, 4'd5, 4'd1, 4'd5, 0, 0);
                4: drive(0, 0, 0, 1, 4'd7, 4'd7, 4'd2, 1, 0);
                6: drive(0, 0, 1, 1, 4'd5, 4'd5, 4'd5, 1, 1);
                default: quiet();
            endcase
            for (int i = 0; i < 2; i++) begin
                total++;
                if (observed(i) !== expected(i)) begin
                    bad++;
                    $display("FAIL load_use[%0d] c%0d: got %h want %h", i, c,
                             observed(i), expected(i));
                end
            end
        end
    endtask

    task automatic test_mem_branch();
        drive(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        for (int c = 0; c < 7; c++) begin
            if (c < 3) drive(0, 1, 1, 1, 4'd3, 4'd3, 4'd0, 1, 0);
            else if (c == 3) drive(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 0, 0);
            else quiet();
            for (int i = 0; i < 2; i++) begin
                total++;
                if (observed(i) !== expected(i)) begin
                    bad++;
                    $display("FAIL mem_branch[%0d] c%0d: got %h want %h", i, c,
                             observed(i), expected(i));
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 12; c++) begin
            drive(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (observed(i) !== expected(i)) begin
                    bad++;
                    $display("FAIL saturation[%0d] c%0d: got %h want %h", i, c,
                             observed(i), expected(i));
                end
            end
        end
        quiet();
        total++;
        if (cntB !== 2'b11) begin
            bad++;
            $display("FAIL saturation_hold: got %0d want 3", cntB);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1));
            for (int i = 0; i < 2; i++) begin
                total++;
                if (observed(i) !== expected(i)) begin
                    bad++;
                    $display("FAIL random[%0d] c%0d: got %h want %h", i, c,
                             observed(i), expected(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mem_stall();
        test_load_use();
        test_mem_branch();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
